mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning): MEM_LATENCY, 1, cycles from issue to valid m_data_out (legal 1..8).
REQ-002 Parameters: STREAK_MAX, 4, max consecutive data grants while fetch waits (legal 1..15).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Ports (name direction width meaning):
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- f_req  in  1  fetch request
- f_addr  in  32  fetch byte address
- f_ack  out  1  fetch done, one-cycle pulse
- f_rdata  out  32  fetch word, valid with f_ack
- d_req  in  1  data request
- d_we  in  1  1=store, 0=load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_size  in  2  00 byte, 01 half, 10 word
- d_ack  out  1  data done, one-cycle pulse
- d_rdata  out  32  load data, valid with d_ack
- m_valid  out  1  memory transaction issue strobe
- m_addr  out  32  memory address
- m_data_in  out  32  memory write data
- m_read_write  out  1  1=write, 0=read
- m_access_size  out  2  memory access size
- m_data_out  in  32  memory read data
- busy  out  1  high in every state except IDLE

Function
REQ-005 SHALL implement states IDLE, ISSUE, WAIT, RESP; one transaction in flight at most.
REQ-006 IDLE: SHALL sample f_req/d_req; if either high, latch winner's fields, go ISSUE; else stay IDLE.
REQ-007 Priority SHALL be data over fetch, except fetch wins when both high and streak == STREAK_MAX.
REQ-008 Streak counter SHALL increment (saturating at STREAK_MAX) on a data grant with f_req=1, clear on a data grant with f_req=0, clear on any fetch grant.
REQ-009 ISSUE: m_valid=1 for exactly one cycle; next state WAIT.
REQ-010 m_addr, m_data_in, m_read_write, m_access_size SHALL hold latched values from ISSUE through last WAIT cycle; all zero in IDLE and RESP.
REQ-011 Fetch transactions SHALL drive m_read_write=0, m_access_size=10, m_data_in=0.
REQ-012 Data transactions SHALL drive m_read_write=d_we, m_access_size=d_size, m_data_in=d_we ? d_wdata : 0.
REQ-013 Addresses SHALL pass unmodified; no alignment checking.
REQ-014 WAIT SHALL last exactly MEM_LATENCY cycles; m_data_out SHALL be registered in the last WAIT cycle; next state RESP.
REQ-015 RESP: assert the owner's ack for one cycle with registered rdata; non-owner ack=0; next state IDLE.
REQ-016 d_rdata SHALL be 0 on a store ack; rdata outputs SHALL hold their last value when ack low.
REQ-017 Latency: request sampled in IDLE cycle T -> m_valid at T+1 -> ack at T+2+MEM_LATENCY; back-to-back period MEM_LATENCY+3.
REQ-018 Requests in ISSUE/WAIT/RESP SHALL be ignored; requester SHALL hold req and fields stable until ack, and may present its next request in the ack cycle.
REQ-019 f_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-020 Reset SHALL force IDLE, streak=0, f_ack=d_ack=m_valid=busy=0, all m_* and rdata outputs 0.
REQ-021 Reset mid-transaction SHALL abandon it: no ack ever issued, late m_data_out ignored.

Verification
REQ-022 Single fetch: f_req=1, f_addr=0x01000000 at T, memory returns 0x00500093 -> m_valid only at T+1 (addr 0x01000000, rw 0, size 10); f_ack at T+3, f_rdata=0x00500093; d_ack 0 throughout.
REQ-023 Simultaneous: both req at T, d_we=1, d_addr=0x01000100, d_wdata=0xDEADBEEF, d_size=00 -> T+1 issue rw 1, size 00, data_in 0xDEADBEEF; d_ack T+3, d_rdata 0; fetch issue T+5, f_ack T+7.
REQ-024 Starvation: f_req and d_req held high continuously, STREAK_MAX=4 -> grant order D,D,D,D,F,D,D,D,D,F.
REQ-025 Reset asserted during WAIT -> next cycle busy 0, m_valid 0; no ack for abandoned request; following fetch completes in 3 cycles with data priority and streak 0.
REQ-026 MEM_LATENCY=3: fetch at T -> m_addr stable T+1..T+4, f_ack at T+5.
REQ-027 d_req pulsed only during a fetch's WAIT cycles -> never issued; only f_ack observed.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters, data first with a fetch anti-starvation streak limit
module mem_port_arbiter #(
   parameter int MEM_LATENCY = 1,
   parameter int STREAK_MAX  = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   output logic        f_ack,
   output logic [31:0] f_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [1:0]  d_size,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        m_valid,
   output logic [31:0] m_addr,
   output logic [31:0] m_data_in,
   output logic        m_read_write,
   output logic [1:0]  m_access_size,
   input  logic [31:0] m_data_out,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t      state, state_nx;
   logic [3:0]  streak, cnt;
   logic        own_d, rw_q, grant_f, grant_d, hold, last_wait;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q;

   assign grant_f   = f_req && (!d_req || streak == 4'(STREAK_MAX));
   assign grant_d   = d_req && !grant_f;
   assign hold      = state == ISSUE || state == WAIT;
   assign last_wait = state == WAIT && cnt == '0;

   always_comb begin
      state_nx      = state == IDLE ? ((f_req || d_req) ? ISSUE : IDLE) :
                      state == ISSUE ? WAIT :
                      state == WAIT ? (last_wait ? RESP : WAIT) : IDLE;
      m_valid       = state == ISSUE;
      busy          = state != IDLE;
      f_ack         = state == RESP && !own_d;
      d_ack         = state == RESP && own_d;
      m_addr        = hold ? addr_q : '0;
      m_data_in     = hold ? wdata_q : '0;
      m_read_write  = hold && rw_q;
      m_access_size = hold ? size_q : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         streak  <= '0;
         cnt     <= '0;
         own_d   <= 1'b0;
         rw_q    <= 1'b0;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         f_rdata <= '0;
         d_rdata <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && (f_req || d_req)) begin
            own_d   <= grant_d;
            addr_q  <= grant_d ? d_addr : f_addr;
            wdata_q <= grant_d && d_we ? d_wdata : '0;
            rw_q    <= grant_d && d_we;
            size_q  <= grant_d ? d_size : 2'b10;
            // streak counts data wins only while fetch is actually waiting
            streak  <= grant_d && f_req ? (streak == 4'(STREAK_MAX) ? streak : streak + 4'd1) : '0;
         end
         cnt     <= state == ISSUE ? 4'(MEM_LATENCY - 1) : state == WAIT ? cnt - 4'd1 : cnt;
         f_rdata <= last_wait && !own_d ? m_data_out : f_rdata;
         d_rdata <= last_wait && own_d ? (rw_q ? '0 : m_data_out) : d_rdata;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with requester agents and a latency-accurate memory model
module tb_mem_port_arbiter;
   localparam int LAT  = 3;
   localparam int SMAX = 4;
   typedef struct {logic d; logic we; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata;} txn_t;

   logic        clock = 1'b0, reset = 1'b1;
   logic        f_req, d_req, d_we, f_ack, d_ack, m_valid, m_read_write, busy;
   logic [31:0] f_addr, f_rdata, d_addr, d_wdata, d_rdata, m_addr, m_data_in, m_data_out;
   logic [1:0]  d_size, m_access_size;
   int          cyc = 0, n_chk = 0, n_err = 0;
   int          f_left = 0, d_left = 0, fa = 0, da = 0, fq = 0, dq = 0;
   int          start_cyc = 0, last_ack = -100, issue_cyc = 0;
   bit          glitch = 1'b0, inflight = 1'b0;
   logic [31:0] f_last = '0, d_last = '0;
   txn_t        cur;
   txn_t        q[$];

   mem_port_arbiter #(.MEM_LATENCY(LAT), .STREAK_MAX(SMAX)) dut (
      .clock(clock), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .m_valid(m_valid), .m_addr(m_addr), .m_data_in(m_data_in), .m_read_write(m_read_write),
      .m_access_size(m_access_size), .m_data_out(m_data_out), .busy(busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic txn_t f_item(int n);
      txn_t t;
      t.d = 1'b0; t.we = 1'b0; t.size = 2'b10; t.wdata = '0;
      t.addr = 32'h0100_0000 + 32'(4 * n);
      return t;
   endfunction

   function automatic txn_t d_item(int n);
      txn_t t;
      t.d = 1'b1; t.we = ~n[0]; t.size = 2'(n % 3);
      t.addr = 32'h0100_0100 + 32'(4 * n);
      t.wdata = 32'hDEAD_BEEF ^ 32'(n);
      return t;
   endfunction

   function automatic logic [31:0] mem(logic [31:0] a);
      return a ^ 32'h0050_0093;
   endfunction

   task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // requesters: hold req and fields until ack, present the next request in the ack cycle
   initial begin
      txn_t ft, dt;
      f_req = 0; d_req = 0; f_addr = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_size = 0;
      forever begin
         @(negedge clock);
         if (f_ack && f_left > 0) begin fa++; f_left--; end
         if (d_ack && d_left > 0) begin da++; d_left--; end
         ft = f_item(fa);
         dt = d_item(da);
         f_req = f_left > 0;
         f_addr = ft.addr;
         d_req = d_left > 0 || glitch;
         d_we = dt.we; d_addr = dt.addr; d_wdata = dt.wdata; d_size = dt.size;
      end
   end

   // monitor and memory model; m_data_out is only correct in the last WAIT cycle
   initial begin
      logic [31:0] exp_rd;
      int e;
      m_data_out = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            inflight = 1'b0; f_last = '0; d_last = '0;
         end else begin
            if (m_valid) begin
               if (q.size() == 0) chk("unexpected_issue", 32'(m_valid), 0);
               else begin
                  cur = q.pop_front();
                  inflight = 1'b1;
                  issue_cyc = cyc;
                  e = last_ack + 2 > start_cyc + 1 ? last_ack + 2 : start_cyc + 1;
                  chk("issue_cyc", 32'(cyc), 32'(e));
                  chk("issue_addr", m_addr, cur.addr);
                  chk("issue_rw", 32'(m_read_write), 32'(cur.d && cur.we));
                  chk("issue_size", 32'(m_access_size), 32'(cur.size));
                  chk("issue_wdata", m_data_in, cur.d && cur.we ? cur.wdata : 32'h0);
               end
            end else if (inflight && cyc <= issue_cyc + LAT) begin
               chk("hold_addr", m_addr, cur.addr);
               chk("hold_size", 32'(m_access_size), 32'(cur.size));
            end
            if (f_ack || d_ack) begin
               if (!inflight) chk("unexpected_ack", 32'({f_ack, d_ack}), 0);
               else begin
                  exp_rd = cur.d && cur.we ? 32'h0 : mem(cur.addr);
                  chk("ack_owner", 32'({f_ack, d_ack}), cur.d ? 32'h1 : 32'h2);
                  chk("ack_cyc", 32'(cyc), 32'(issue_cyc + LAT + 1));
                  chk("resp_m_addr", m_addr, 0);
                  if (cur.d) begin
                     chk("d_rdata", d_rdata, exp_rd);
                     chk("f_rdata_hold", f_rdata, f_last);
                     d_last = exp_rd;
                  end else begin
                     chk("f_rdata", f_rdata, exp_rd);
                     chk("d_rdata_hold", d_rdata, d_last);
                     f_last = exp_rd;
                  end
                  inflight = 1'b0;
                  last_ack = cyc;
               end
            end
            m_data_out = inflight && cyc == issue_cyc + LAT ? mem(cur.addr) : 32'hBAD0_0000 | 32'(cyc);
         end
      end
   end

   task automatic launch(int nf, int nd, string order);
      @(posedge clock); #1;
      start_cyc = cyc;
      for (int i = 0; i < order.len(); i++) begin
         if (order[i] == "D") begin q.push_back(d_item(dq)); dq++; end
         else begin q.push_back(f_item(fq)); fq++; end
      end
      f_left = nf;
      d_left = nd;
   endtask

   task automatic wait_idle(string tag);
      int t = 0;
      while ((q.size() != 0 || inflight || f_left != 0 || d_left != 0) && t < 500) begin
         @(posedge clock); #1;
         t++;
      end
      chk(tag, 32'(t >= 500), 0);
   endtask

   initial begin
      int t;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_f_ack", 32'(f_ack), 0);
      chk("rst_d_ack", 32'(d_ack), 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_data_in", m_data_in, 0);
      chk("rst_m_rw", 32'(m_read_write), 0);
      chk("rst_m_size", 32'(m_access_size), 0);
      chk("rst_f_rdata", f_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      reset = 1'b0;
      launch(1, 0, "F");
      wait_idle("single_fetch_timeout");
      launch(1, 1, "DF");
      wait_idle("simultaneous_timeout");
      launch(2, 8, "DDDDFDDDDF");
      wait_idle("starvation_timeout");
      launch(1, 0, "F");
      repeat (2) begin @(posedge clock); #1; end
      glitch = 1'b1;
      repeat (LAT - 1) begin @(posedge clock); #1; end
      glitch = 1'b0;
      wait_idle("wait_pulse_timeout");
      // build streak to the limit, then reset in the fourth data transaction's WAIT
      launch(1, 5, "DDDD");
      t = 0;
      while (q.size() != 0 && t < 300) begin @(posedge clock); #1; t++; end
      chk("pre_reset_timeout", 32'(t >= 300), 0);
      reset = 1'b1; f_left = 0; d_left = 0; dq--;
      @(posedge clock); #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_m_valid", 32'(m_valid), 0);
      reset = 1'b0;
      launch(1, 1, "DF");
      wait_idle("post_reset_timeout");
      repeat (LAT + 4) @(posedge clock);
      #1;
      chk("sb_empty", 32'(q.size()), 0);
      chk("fetch_acks", 32'(fa), 32'(fq));
      chk("data_acks", 32'(da), 32'(dq));
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got cycle %0d want finish", cyc);
      $fatal(1, "timeout");
   end
endmodule
